imem_responder: RTL and testbench

- Responder end of the CPU instruction-fetch interface. The CPU datapath is the initiator; this block answers its fetch requests from an internal word-organised program memory.
- Uses a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states per fetch.
- Provides a side write port so a testbench or boot loader can preload the program.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_array.sv | 23 ++
 rtl/imem_responder.sv | 115 +++++++++++
 tb/tb_imem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam int DEF_DEPTH       = 256;
  localparam int DEF_AW          = 8;
  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A fetch is in error when it is not word aligned or points past the
  // last word of a memory whose word index is aw bits wide.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-organised program storage: synchronous write, combinational read.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents survive reset on purpose: a preloaded program must outlive it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Responder side of the instruction-fetch interface with programmable
// wait states, a side load port and a saturating completion counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The initiator holds valid and payload steady until that edge;
// this block holds resp_valid/resp_data/resp_err steady until resp_ready.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AW          = DEF_AW,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [31:0]      load_data,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state, state_nx;
  logic [3:0]    wcnt;
  logic [AW-1:0] idx_q;
  logic          err_q;
  logic [AW-1:0] cap_idx;
  logic          cap_err;
  logic          capture;
  logic [31:0]   rdata;

  // With zero wait states the capture happens in the accept cycle itself,
  // so the request inputs feed the read port directly while in IDLE.
  assign cap_idx = (state == IDLE) ? req_addr[AW+1:2] : idx_q;
  assign cap_err = (state == IDLE) ? addr_err(req_addr, AW) : err_q;
  assign capture = (state != RESP) && (state_nx == RESP);

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (cap_idx),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (wcnt == 4'd0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, wait counter, response capture and completion counter.
  // The capture reads the array before any same-edge load lands, so a
  // coinciding load returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt        <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      resp_data   <= 32'd0;
      resp_err    <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        idx_q <= req_addr[AW+1:2];
        err_q <= cap_err;
        wcnt  <= WS_INIT;
      end else if (state == WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (capture) begin
        resp_data <= cap_err ? 32'd0 : rdata;
        resp_err  <= cap_err;
      end
      if (state == RESP && resp_ready && fetch_count != {CNT_W{1'b1}}) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
    state_dbg  = state;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two builds (2 wait states / 16-bit counter and
// 0 wait states / 2-bit counter) against a queue-based reference model.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- per-build stimulus ----------------
  logic [1:0]       req_valid, resp_ready, load_en;
  logic [1:0][31:0] req_addr, load_data;
  logic [1:0][7:0]  load_addr;

  // ---------------- per-build observations ----------------
  logic        rdy_0, vld_0, err_0, busy_0, rdy_1, vld_1, err_1, busy_1;
  logic [31:0] data_0, data_1;
  logic [15:0] cnt_0;
  logic [1:0]  cnt_1, st_0, st_1;

  logic [1:0]       o_rdy, o_vld, o_err, o_busy;
  logic [1:0][31:0] o_data;
  logic [1:0][15:0] o_cnt;
  logic [1:0][1:0]  o_st;

  always_comb begin
    o_rdy  = {rdy_1, rdy_0};
    o_vld  = {vld_1, vld_0};
    o_err  = {err_1, err_0};
    o_busy = {busy_1, busy_0};
    o_data = {data_1, data_0};
    o_cnt  = {{14'd0, cnt_1}, cnt_0};
    o_st   = {st_1, st_0};
  end

  imem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(rdy_0), .req_addr(req_addr[0]),
    .resp_valid(vld_0), .resp_ready(resp_ready[0]), .resp_data(data_0), .resp_err(err_0),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
    .busy(busy_0), .fetch_count(cnt_0), .state_dbg(st_0)
  );

  imem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(rdy_1), .req_addr(req_addr[1]),
    .resp_valid(vld_1), .resp_ready(resp_ready[1]), .resp_data(data_1), .resp_err(err_1),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
    .busy(busy_1), .fetch_count(cnt_1), .state_dbg(st_1)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_m [2][DEPTH];
  int unsigned cnt_m [2];
  logic [32:0] exp_q [$];   // {err, data}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ws_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int unsigned cmax_of(input int u);
    return (u == 0) ? 32'd65535 : 32'd3;
  endfunction

  // Expected response. A load issued lc cycles after the accept cycle lands
  // before the capture only when lc is smaller than the number of wait states.
  function automatic logic [32:0] model_resp(input int u, input logic [31:0] addr,
                                             input int lc, input logic [7:0] li,
                                             input logic [31:0] ld);
    logic        err;
    logic [7:0]  wi;
    logic [31:0] d;
    err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
    wi  = 8'(addr / 4);
    d   = mem_m[u][wi];
    if (lc >= 0 && lc < ws_of(u) && li == wi) d = ld;
    return {err, err ? 32'd0 : d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_word(input int u, input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    load_en[u] = 1'b1; load_addr[u] = idx; load_data[u] = d;
    @(negedge clk);
    load_en[u] = 1'b0;
    mem_m[u][idx] = d;
  endtask

  task automatic check_reset_state(input int u, input string tag);
    check({tag, "_valid"}, o_vld[u], 0);
    check({tag, "_busy"},  o_busy[u], 0);
    check({tag, "_ready"}, o_rdy[u], 1);
    check({tag, "_count"}, o_cnt[u], cnt_m[u]);
    check({tag, "_state"}, o_st[u], IDLE);
  endtask

  task automatic fetch(input int u, input logic [31:0] addr, input int hold,
                       input int lc, input logic [7:0] li, input logic [31:0] ld);
    logic [32:0] exp;
    logic [31:0] held;
    int n;
    @(negedge clk);
    check("idle_ready", o_rdy[u], 1);
    exp_q.push_back(model_resp(u, addr, lc, li, ld));
    req_valid[u] = 1'b1; req_addr[u] = addr; resp_ready[u] = 1'b0;
    load_en[u] = (lc == 0); load_addr[u] = li; load_data[u] = ld;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid[u] = 1'b0; req_addr[u] = $urandom;
      load_en[u] = (lc == n); load_addr[u] = li; load_data[u] = ld;
    end while (!o_vld[u] && n < 20);
    load_en[u] = 1'b0;
    if (lc >= 0) mem_m[u][li] = ld;
    check("latency", n, ws_of(u) + 1);
    exp = exp_q.pop_front();
    check("resp_data", o_data[u], exp[31:0]);
    check("resp_err", o_err[u], exp[32]);
    held = o_data[u];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", o_vld[u], 1);
      check("hold_data", o_data[u], held);
      check("hold_ready", o_rdy[u], 0);
      check("hold_busy", o_busy[u], 1);
    end
    // A request offered during the handshake cycle must be ignored.
    resp_ready[u] = 1'b1; req_valid[u] = 1'b1; req_addr[u] = addr ^ 32'h4;
    @(negedge clk);
    resp_ready[u] = 1'b0; req_valid[u] = 1'b0;
    if (cnt_m[u] != cmax_of(u)) cnt_m[u]++;
    check_reset_state(u, "done");
    check("data_kept", o_data[u], held);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      2:       return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      default: return $urandom | 32'h400;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int lc;
    logic [7:0] li;
    reset = 1'b0;
    req_valid = '0; resp_ready = '0; load_en = '0;
    req_addr = '0; load_addr = '0; load_data = '0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_reset_state(u, "rst");
      check("rst_data", o_data[u], 0);
      check("rst_err", o_err[u], 0);
    end
    reset = 1'b1;

    // Fill both memories so every fetch has a known word.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        mem_m[u][i] = $urandom;
        load_en[u] = 1'b1; load_addr[u] = 8'(i); load_data[u] = mem_m[u][i];
      end
    end
    @(negedge clk);
    load_en = '0;
    load_word(0, 8'd3, 32'hDEADBEEF);

    // Reset during WAIT aborts the fetch; memory survives.
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h0C;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("abort_busy_before", o_busy[0], 1);
    reset = 1'b0;
    #1;
    check_reset_state(0, "abort");
    @(negedge clk);
    reset = 1'b1;

    // Directed fetches on the two-wait-state build.
    fetch(0, 32'h0C, 0, -1, 8'd0, 32'd0);
    fetch(0, 32'h0E, 0, -1, 8'd0, 32'd0);
    fetch(0, 32'h400, 0, -1, 8'd0, 32'd0);
    fetch(0, 32'h0C, 5, -1, 8'd0, 32'd0);
    load_word(0, 8'd5, 32'h11111111);
    fetch(0, 32'h14, 0, 1, 8'd5, 32'h22222222);
    load_word(0, 8'd5, 32'h11111111);
    fetch(0, 32'h14, 0, 2, 8'd5, 32'h22222222);

    // Randomized fetches with backpressure and colliding loads.
    for (int k = 0; k < 40; k++) begin
      a  = rand_addr();
      lc = $urandom_range(0, 3) - 1;
      li = ($urandom_range(0, 1) == 1) ? 8'(a >> 2) : 8'($urandom_range(0, 255));
      fetch(0, a, $urandom_range(0, 3), lc, li, $urandom);
    end

    // Zero-wait-state build: latency, collision at capture, saturation.
    fetch(1, 32'h0C, 0, -1, 8'd0, 32'd0);
    load_word(1, 8'd5, 32'h11111111);
    fetch(1, 32'h14, 0, 0, 8'd5, 32'h22222222);
    for (int k = 0; k < 6; k++) begin
      a = rand_addr();
      fetch(1, a, $urandom_range(0, 2), -1, 8'd0, 32'd0);
    end
    check("sat_count", o_cnt[1], 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
